// File: rtl/note_lane_pkg.sv
// Shared screen geometry and FSM state encoding for the note lane engine.
package note_lane_pkg;

    localparam int SCR_W = 320;
    localparam int SCR_H = 240;
    localparam int X_W   = 9;
    localparam int Y_W   = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_FETCH = 3'd2,
        ST_SHIFT = 3'd3,
        ST_DRAW  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/note_hit_scorer.sv
// Scores the hit row against player inputs: popcount of hits, doubled once the
// clean-shift streak reaches STREAK_2X, accumulated into a saturating score.
module note_hit_scorer #(
    parameter int NUM_LANES = 3,
    parameter int SCORE_W   = 8,
    parameter int STREAK_2X = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 clear_i,
    input  logic                 score_en_i,
    input  logic [NUM_LANES:0]   row0_i,
    input  logic [NUM_LANES-1:0] notes_i,
    output logic [SCORE_W-1:0]   score_o
);

    localparam int HW  = $clog2(NUM_LANES + 1);
    localparam int PW  = HW + 1;
    localparam int SKW = $clog2(STREAK_2X + 1);

    logic [SCORE_W-1:0]   score_q, score_d;
    logic [SKW-1:0]       streak_q, streak_d;
    logic [NUM_LANES-1:0] row_notes, hit_vec;
    logic                 row_hold;
    logic [HW-1:0]        hits;
    logic [PW-1:0]        pts;
    logic [SCORE_W:0]     sum;

    assign row_notes = row0_i[NUM_LANES-1:0];
    assign row_hold  = row0_i[NUM_LANES];
    assign hit_vec   = row_notes & notes_i;

    always_comb begin
        hits = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            hits = hits + HW'(hit_vec[i]);
        end
    end

    assign pts = (streak_q >= SKW'(STREAK_2X)) ? {hits, 1'b0} : {1'b0, hits};
    assign sum = {1'b0, score_q} + (SCORE_W + 1)'(pts);

    // The streak only needs to reach STREAK_2X, so it saturates there.
    always_comb begin
        score_d  = score_q;
        streak_d = streak_q;
        if (clear_i) begin
            score_d  = '0;
            streak_d = '0;
        end else if (score_en_i) begin
            score_d = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
            if (row_notes != '0 && !row_hold) begin
                if (hit_vec == row_notes) begin
                    if (streak_q != SKW'(STREAK_2X)) begin
                        streak_d = streak_q + 1'b1;
                    end
                end else begin
                    streak_d = '0;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            score_q  <= '0;
            streak_q <= '0;
        end else begin
            score_q  <= score_d;
            streak_q <= streak_d;
        end
    end

    assign score_o = score_q;

endmodule

// File: rtl/note_lane_engine.sv
// Streams song words into the note window, scores hits and emits one box request per cell.
// IDLE: no song | WAIT: await tick | FETCH: ROM read | SHIFT: shift+score | DRAW: boxes | DONE: latch final
module note_lane_engine
    import note_lane_pkg::*;
#(
    parameter int NUM_LANES    = 3,
    parameter int VISIBLE_ROWS = 4,
    parameter int SONG_LEN     = 59,
    parameter int SONG_AW      = 6,
    parameter int BOX_W        = 30,
    parameter int LANE_H       = 60,
    parameter int X0           = 0,
    parameter int Y0           = 60,
    parameter int SCORE_W      = 8,
    parameter int STREAK_2X    = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 shift_song,
    input  logic [NUM_LANES-1:0] notes_in,
    output logic                 song_rd,
    output logic [SONG_AW-1:0]   song_addr,
    input  logic [NUM_LANES:0]   song_word,
    output logic                 box_valid,
    input  logic                 box_ready,
    output logic [X_W-1:0]       box_x,
    output logic [Y_W-1:0]       box_y,
    output logic                 box_filled,
    output logic                 box_hold,
    output logic                 busy,
    output logic [SCORE_W-1:0]   score,
    output logic [SCORE_W-1:0]   final_score,
    output logic                 done,
    output logic                 overrun
);

    localparam int LW    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int RW    = (VISIBLE_ROWS > 1) ? $clog2(VISIBLE_ROWS) : 1;
    localparam int TOTAL = SONG_LEN + VISIBLE_ROWS;
    localparam int CW    = $clog2(TOTAL + 1);
    localparam logic [LW-1:0] LANE_LAST = LW'(NUM_LANES - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(VISIBLE_ROWS - 1);

    if (X0 + (VISIBLE_ROWS - 1) * BOX_W >= SCR_W) begin : g_x_range
        $error("note window exceeds screen width");
    end
    if (Y0 + (NUM_LANES - 1) * LANE_H >= SCR_H) begin : g_y_range
        $error("note window exceeds screen height");
    end

    state_t                              state_q, state_d;
    logic [VISIBLE_ROWS-1:0][NUM_LANES:0] win_q;
    logic [SONG_AW:0]                    idx_q;
    logic [CW-1:0]                       left_q;
    logic [LW-1:0]                       lane_q;
    logic [RW-1:0]                       row_q;
    logic                                pend_q, overrun_q;
    logic [SCORE_W-1:0]                  final_q, score_w;
    logic                                idx_ok, in_draw, hs, last_cell, start_ok, tick_busy;
    logic [NUM_LANES:0]                  cell_row;

    assign idx_ok    = idx_q < (SONG_AW + 1)'(SONG_LEN);
    assign in_draw   = state_q == ST_DRAW;
    assign hs        = in_draw && box_ready;
    assign last_cell = (lane_q == LANE_LAST) && (row_q == ROW_LAST);
    assign start_ok  = (state_q == ST_IDLE) && start;
    assign tick_busy = shift_song && (state_q == ST_FETCH || state_q == ST_SHIFT || in_draw);

    // A tick that arrived during the previous row skips WAIT entirely.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start) state_d = ST_WAIT;
            ST_WAIT:  if (shift_song) state_d = ST_FETCH;
            ST_FETCH: state_d = ST_SHIFT;
            ST_SHIFT: state_d = ST_DRAW;
            ST_DRAW: begin
                if (hs && last_cell) begin
                    if (left_q == '0)                state_d = ST_DONE;
                    else if (pend_q || shift_song)   state_d = ST_FETCH;
                    else                             state_d = ST_WAIT;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            win_q     <= '0;
            idx_q     <= '0;
            left_q    <= '0;
            lane_q    <= '0;
            row_q     <= '0;
            pend_q    <= 1'b0;
            overrun_q <= 1'b0;
            final_q   <= '0;
        end else begin
            state_q <= state_d;
            if (start_ok) begin
                idx_q     <= '0;
                left_q    <= CW'(TOTAL);
                pend_q    <= 1'b0;
                overrun_q <= 1'b0;
            end
            if (tick_busy) begin
                pend_q <= 1'b1;
                if (pend_q) overrun_q <= 1'b1;
            end
            if (in_draw && state_d != ST_DRAW) pend_q <= 1'b0;
            if (state_q == ST_SHIFT) begin
                for (int r = 0; r < VISIBLE_ROWS - 1; r++) begin
                    win_q[r] <= win_q[r+1];
                end
                win_q[VISIBLE_ROWS-1] <= idx_ok ? song_word : '0;
                if (idx_ok) idx_q <= idx_q + 1'b1;
                left_q <= left_q - 1'b1;
                lane_q <= '0;
                row_q  <= '0;
            end
            if (hs) begin
                if (row_q == ROW_LAST) begin
                    row_q  <= '0;
                    lane_q <= (lane_q == LANE_LAST) ? '0 : lane_q + 1'b1;
                end else begin
                    row_q <= row_q + 1'b1;
                end
            end
            if (state_q == ST_DONE) final_q <= score_w;
        end
    end

    note_hit_scorer #(
        .NUM_LANES (NUM_LANES),
        .SCORE_W   (SCORE_W),
        .STREAK_2X (STREAK_2X)
    ) u_scorer (
        .clock      (clock),
        .reset      (reset),
        .clear_i    (start_ok || state_q == ST_DONE),
        .score_en_i (state_q == ST_SHIFT),
        .row0_i     (win_q[0]),
        .notes_i    (notes_in),
        .score_o    (score_w)
    );

    assign cell_row    = win_q[row_q];
    assign box_valid   = in_draw;
    assign box_filled  = in_draw && cell_row[lane_q];
    assign box_hold    = in_draw && cell_row[NUM_LANES] && cell_row[lane_q];
    assign box_x       = in_draw ? X_W'(X0) + X_W'(row_q) * X_W'(BOX_W) : '0;
    assign box_y       = in_draw ? Y_W'(Y0) + Y_W'(lane_q) * Y_W'(LANE_H) : '0;
    assign song_rd     = (state_q == ST_FETCH) && idx_ok;
    assign song_addr   = (state_q == ST_FETCH) ? idx_q[SONG_AW-1:0] : '0;
    assign busy        = state_q != ST_IDLE;
    assign done        = state_q == ST_DONE;
    assign overrun     = overrun_q;
    assign score       = score_w;
    assign final_score = final_q;

endmodule
